// File: rtl/wb_stage.sv
// Writeback stage: merges ALU results and in-order load responses onto the regfile write port,
// tracks outstanding loads in a small queue with a per-register busy scoreboard. Optional macro: WB_PERF_EN.
module wb_stage #(
  parameter int WIDTH    = 32,
  parameter int ADDR     = 5,
  parameter int LQ_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 alu_valid,
  output logic                 alu_ready,
  input  logic [ADDR-1:0]      alu_rd,
  input  logic [WIDTH-1:0]     alu_data,
  input  logic                 ld_issue_valid,
  output logic                 ld_issue_ready,
  input  logic [ADDR-1:0]      ld_issue_rd,
  input  logic [2:0]           ld_issue_funct3,
  input  logic [1:0]           ld_issue_addr_lo,
  input  logic                 mem_rvalid,
  input  logic [WIDTH-1:0]     mem_rdata,
  output logic [2**ADDR-1:0]   busy,
  output logic                 wr_en,
  output logic [ADDR-1:0]      rd,
  output logic [WIDTH-1:0]     wdata
`ifdef WB_PERF_EN
  ,
  output logic [31:0]          perf_loads,
  output logic [31:0]          perf_alu_stalls
`endif
);

  localparam int PTR_W = $clog2(LQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int NREG  = 2**ADDR;

  logic [ADDR-1:0]  lq_rd_q   [LQ_DEPTH];
  logic [ADDR-1:0]  lq_rd_d   [LQ_DEPTH];
  logic [2:0]       lq_f3_q   [LQ_DEPTH];
  logic [2:0]       lq_f3_d   [LQ_DEPTH];
  logic [1:0]       lq_lo_q   [LQ_DEPTH];
  logic [1:0]       lq_lo_d   [LQ_DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [NREG-1:0]  busy_q, busy_d;
  logic             wr_en_q, wr_en_d;
  logic [ADDR-1:0]  rd_q, rd_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;

  logic             full, empty, push, pop, alu_fire;
  logic [ADDR-1:0]  head_rd;
  logic [2:0]       head_f3;
  logic [1:0]       head_lo;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [WIDTH-1:0] ld_val;

  assign full           = (count_q == CNT_W'(LQ_DEPTH));
  assign empty          = (count_q == '0);
  assign ld_issue_ready = !full && !busy_q[ld_issue_rd];
  assign alu_ready      = !mem_rvalid && !busy_q[alu_rd];
  assign push           = ld_issue_valid && ld_issue_ready;
  assign pop            = mem_rvalid && !empty;
  assign alu_fire       = alu_valid && alu_ready;

  assign head_rd = lq_rd_q[head_q];
  assign head_f3 = lq_f3_q[head_q];
  assign head_lo = lq_lo_q[head_q];

  // Halfword select uses only addr_lo[1]; misaligned low bits are dropped.
  always_comb begin
    ld_byte = mem_rdata[{head_lo, 3'b000} +: 8];
    ld_half = mem_rdata[{head_lo[1], 4'b0000} +: 16];
    case (head_f3)
      3'b000:  ld_val = {{(WIDTH-8){ld_byte[7]}}, ld_byte};
      3'b001:  ld_val = {{(WIDTH-16){ld_half[15]}}, ld_half};
      3'b100:  ld_val = {{(WIDTH-8){1'b0}}, ld_byte};
      3'b101:  ld_val = {{(WIDTH-16){1'b0}}, ld_half};
      default: ld_val = mem_rdata;
    endcase
  end

  always_comb begin
    lq_rd_d = lq_rd_q;
    lq_f3_d = lq_f3_q;
    lq_lo_d = lq_lo_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    busy_d  = busy_q;
    wr_en_d = 1'b0;
    rd_d    = rd_q;
    wdata_d = wdata_q;

    if (push) begin
      lq_rd_d[tail_q] = ld_issue_rd;
      lq_f3_d[tail_q] = ld_issue_funct3;
      lq_lo_d[tail_q] = ld_issue_addr_lo;
      tail_d          = tail_q + PTR_W'(1);
    end
    if (pop) begin
      busy_d[head_rd] = 1'b0;
      head_d          = head_q + PTR_W'(1);
    end
    // Set after clear so a same-cycle set on the same index wins.
    if (push) busy_d[ld_issue_rd] = 1'b1;
    busy_d[0] = 1'b0;

    if (pop) begin
      wr_en_d = (head_rd != '0);
      rd_d    = head_rd;
      wdata_d = ld_val;
    end else if (alu_fire) begin
      wr_en_d = (alu_rd != '0);
      rd_d    = alu_rd;
      wdata_d = alu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lq_rd_q <= '{default: '0};
      lq_f3_q <= '{default: '0};
      lq_lo_q <= '{default: '0};
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      busy_q  <= '0;
      wr_en_q <= 1'b0;
      rd_q    <= '0;
      wdata_q <= '0;
    end else begin
      lq_rd_q <= lq_rd_d;
      lq_f3_q <= lq_f3_d;
      lq_lo_q <= lq_lo_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      wr_en_q <= wr_en_d;
      rd_q    <= rd_d;
      wdata_q <= wdata_d;
    end
  end

  assign busy  = busy_q;
  assign wr_en = wr_en_q;
  assign rd    = rd_q;
  assign wdata = wdata_q;

`ifdef WB_PERF_EN
  logic [31:0] perf_loads_q, perf_loads_d, perf_stalls_q, perf_stalls_d;

  always_comb begin
    perf_loads_d  = perf_loads_q + 32'(pop);
    perf_stalls_d = perf_stalls_q + 32'(alu_valid && !alu_ready);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      perf_loads_q  <= '0;
      perf_stalls_q <= '0;
    end else begin
      perf_loads_q  <= perf_loads_d;
      perf_stalls_q <= perf_stalls_d;
    end
  end

  assign perf_loads      = perf_loads_q;
  assign perf_alu_stalls = perf_stalls_q;
`endif

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage for the RV32I pipeline; the sole driver of the register file write port (wr_en/rd/wdata).
- Merges two sources: in-order ALU results, and load responses from data memory. Load responses are aligned and sign/zero-extended here.
- Keeps an in-order queue of outstanding loads and a per-register busy scoreboard, which the issue logic uses to stall RAW/WAW on pending loads.

Parameters:
- WIDTH, 32, data width.
- ADDR, 5, register index width.
- LQ_DEPTH, 2, outstanding-load queue entries (power of 2, >=2).

Ports:
- clk  in  1  clock, posedge.
- reset_n  in  1  synchronous, active-low reset.
- alu_valid  in  1  ALU result present.
- alu_ready  out  1  ALU result accepted this cycle.
- alu_rd  in  ADDR  ALU destination.
- alu_data  in  WIDTH  ALU result.
- ld_issue_valid  in  1  load issued to memory.
- ld_issue_ready  out  1  load issue accepted.
- ld_issue_rd  in  ADDR  load destination.
- ld_issue_funct3  in  3  load type.
- ld_issue_addr_lo  in  2  byte address bits [1:0].
- mem_rvalid  in  1  load data returning, in issue order.
- mem_rdata  in  WIDTH  raw aligned word.
- busy  out  2**ADDR  scoreboard, bit i = load pending to xi.
- wr_en  out  1  register file write enable.
- rd  out  ADDR  write index.
- wdata  out  WIDTH  write data.

Behaviour:
- Reset: synchronous, active-low. Queue emptied; busy=0; wr_en=0, rd=0, wdata=0. Reset mid-operation discards every queued load. A mem_rvalid arriving after reset finds an empty queue and is ignored.
- Write outputs (wr_en, rd, wdata) are registered on posedge.
  - The register file writes on negedge, so a write is visible to readers in the same cycle it is presented.
  - Latency: source accepted in cycle N gives wr_en=1 in cycle N+1.
- Load queue:
  - Push on ld_issue_valid && ld_issue_ready, storing {rd, funct3, addr_lo}.
  - Pop the head on mem_rvalid.
  - Push and pop in the same cycle are both allowed.
- ld_issue_ready = !full && !busy[ld_issue_rd]. This enforces at most one pending load per register and keeps loads in order.
- Load alignment on pop: shift = addr_lo*8.
  - 000 LB: sign-extend byte.
  - 001 LH: sign-extend halfword at addr_lo[1]*16.
  - 010 LW: full word.
  - 100 LBU: zero-extend byte.
  - 101 LHU: zero-extend halfword.
  - Any other funct3 is treated as LW.
  - Misaligned LH/LW: addr_lo low bits are ignored beyond the rules above.
- Arbitration: load response has priority. alu_ready = !mem_rvalid && !busy[alu_rd] (combinational). ALU results are never buffered; EX holds until alu_ready.
- Scoreboard:
  - busy[ld_issue_rd] is set on push.
  - busy[head.rd] is cleared on pop.
  - Same-cycle set and clear of the same index: set wins.
  - busy[0] is always 0.
- x0: any accepted source with rd=0 is consumed, but wr_en stays 0 the next cycle. Loads to x0 still occupy a queue slot.
- mem_rvalid with an empty queue: protocol violation; ignored, no write, no state change.

Optional Feature:
- Macro: WB_PERF_EN.
- When defined:
  - Adds outputs perf_loads (32) and perf_alu_stalls (32).
  - perf_loads counts pops.
  - perf_alu_stalls counts cycles with alu_valid && !alu_ready.
  - Both counters reset to 0 and wrap modulo 2^32.
- When undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- ALU write: alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF, no load → alu_ready=1; next cycle wr_en=1, rd=5, wdata=0xDEADBEEF.
- Load extension: issue LB rd=3 addr_lo=3, then mem_rdata=0x80FF1234 → wdata=0xFFFFFF80. Repeat with LBU → 0x00000080. LH addr_lo=2 → 0xFFFF80FF. LHU addr_lo=0 → 0x00001234.
- Scoreboard stall: issue load rd=7 → busy[7]=1. alu_valid rd=7 → alu_ready=0 until the response; wr_en rd=7 the cycle after mem_rvalid; busy[7]=0 in that cycle; ALU write to x7 the following cycle.
- Collision: mem_rvalid and alu_valid (rd=9) in the same cycle → load written at N+1, alu_ready=1 at N+1, ALU written at N+2.
- Full/x0: two loads to rd=1,2 without response → ld_issue_ready=0. One response pops and frees a slot. ALU to rd=0 → alu_ready=1, wr_en=0.
- Reset mid-op: two loads queued, reset_n=0 for 1 cycle → busy=0, ld_issue_ready=1, wr_en=0. A subsequent mem_rvalid produces no write.
